// File: rtl/mem_traffic_pkg.sv
// Shared types for the memory traffic generator: FSM states, access-pattern phases
// and the LFSR feedback mask.
package mem_traffic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_NEXTPH = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_FULL   = 2'd0,
        PH_SMALL  = 2'd1,
        PH_SEQ    = 2'd2,
        PH_TWOSET = 2'd3
    } phase_t;

    // Galois feedback mask for taps 32,22,2,1 in the right-shifting form.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Lowest enabled phase at or above 'from'; bit 2 of the result says whether one exists.
    function automatic logic [2:0] find_phase(input logic [3:0] en, input logic [2:0] from);
        logic [2:0] result;
        result = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (en[i] && (3'(i) >= from)) result = {1'b1, 2'(i)};
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_traffic_lfsr.sv
// Free-running 32-bit Galois LFSR; advances every cycle outside reset and supplies
// all of the generator's pseudo-random decisions, addresses and data.
module mem_traffic_lfsr
    import mem_traffic_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_1234
)(
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] q
);

    logic [31:0] r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= SEED;
        else     r_state <= r_state[0] ? ((r_state >> 1) ^ LFSR_TAPS) : (r_state >> 1);
    end

    assign q = r_state;

endmodule

// File: rtl/mem_traffic_gen.sv
// Traffic generator and reply checker for a mem_system-style cache port: walks the
// enabled access-pattern phases, checks reply latency classes and counts requests/hits.
module mem_traffic_gen
    import mem_traffic_pkg::*;
#(
    parameter int          ADDR_W       = 16,
    parameter int          DATA_W       = 16,
    parameter int          OFFSET_W     = 3,
    parameter int          INDEX_W      = 8,
    parameter int          PHASE_REQS   = 1000,
    parameter logic [3:0]  PHASE_EN     = 4'b1111,
    parameter logic [31:0] SMALL_TAG    = 32'h3,
    parameter int          SEQ_SPAN     = 9,
    parameter int          HIT_MAX_LAT  = 2,
    parameter int          MISS_MAX_LAT = 20,
    parameter int          TIMEOUT      = 63,
    parameter logic [31:0] SEED         = 32'hACE1_1234
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              Stall,
    input  logic              Done,
    input  logic              CacheHit,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] DataIn,
    output logic              Rd,
    output logic              Wr,
    output logic [1:0]        phase,
    output logic              busy,
    output logic              finished,
    output logic              err_latency,
    output logic              err_dropped,
    output logic              err_protocol,
    output logic [31:0]       n_requests,
    output logic [31:0]       n_hits
);

    localparam int                 TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
    localparam int                 LAT_W     = $clog2(TIMEOUT + 1);
    localparam logic [LAT_W-1:0]   LAT_TMO   = LAT_W'(TIMEOUT);
    localparam logic [INDEX_W-1:0] SPAN_LAST = INDEX_W'(SEQ_SPAN - 1);
    localparam logic [31:0]        LAST_REQ  = 32'(PHASE_REQS - 1);

    state_t              r_state;
    phase_t              r_phase;
    logic [INDEX_W-1:0]  r_idx;
    logic [TAG_W-1:0]    r_tag;
    logic                r_pairSecond;
    logic [LAT_W-1:0]    r_lat;
    logic [31:0]         r_phCnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_dataIn;
    logic                r_rd, r_wr, r_busy, r_finished;
    logic                r_errLat, r_errDrop, r_errProt;
    logic [31:0]         r_nReq, r_nHits;

    logic [31:0]         w_lfsr;
    logic [INDEX_W-1:0]  w_idxNext, w_idxTwo;
    logic [TAG_W-1:0]    w_tagTwo;
    logic [ADDR_W-1:0]   w_addr;
    logic [LAT_W-1:0]    w_latNext;
    logic [31:0]         w_lat32;
    logic                w_hitOk, w_missOk;
    logic [2:0]          w_firstPh, w_nextPh;

    mem_traffic_lfsr #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr)
    );

    // Two-set pairs: the first access moves to a new index with tag = index, the second
    // reuses that index with the next tag so both lines fight over the same set.
    always_comb begin
        w_idxNext = (r_idx == SPAN_LAST) ? '0 : r_idx + 1'b1;
        w_idxTwo  = r_pairSecond ? r_idx : w_idxNext;
        w_tagTwo  = r_pairSecond ? r_tag + 1'b1 : TAG_W'(w_idxNext);
        case (r_phase)
            PH_FULL:  w_addr = w_lfsr[ADDR_W-1:0];
            PH_SMALL: w_addr = {SMALL_TAG[TAG_W-1:0], w_lfsr[INDEX_W+OFFSET_W-1:0]};
            PH_SEQ:   w_addr = {{TAG_W{1'b0}}, r_idx, {OFFSET_W{1'b0}}};
            default:  w_addr = {w_tagTwo, w_idxTwo, {OFFSET_W{1'b0}}};
        endcase
        w_addr[0] = 1'b0;
    end

    assign w_latNext = r_lat + 1'b1;
    assign w_lat32   = 32'(r_lat);
    assign w_hitOk   = (w_lat32 <= 32'(HIT_MAX_LAT));
    assign w_missOk  = (w_lat32 > 32'(HIT_MAX_LAT)) && (w_lat32 <= 32'(MISS_MAX_LAT));
    assign w_firstPh = find_phase(PHASE_EN, 3'd0);
    assign w_nextPh  = find_phase(PHASE_EN, {1'b0, r_phase} + 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_phase      <= PH_FULL;
            r_idx        <= '0;
            r_tag        <= '0;
            r_pairSecond <= 1'b0;
            r_lat        <= '0;
            r_phCnt      <= '0;
            r_addr       <= '0;
            r_dataIn     <= '0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_busy       <= 1'b0;
            r_finished   <= 1'b0;
            r_errLat     <= 1'b0;
            r_errDrop    <= 1'b0;
            r_errProt    <= 1'b0;
            r_nReq       <= '0;
            r_nHits      <= '0;
        end else begin
            if (Done && (r_state != ST_WAIT)) r_errProt <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_phCnt      <= '0;
                        r_idx        <= '0;
                        r_tag        <= '0;
                        r_pairSecond <= 1'b0;
                        if (w_firstPh[2]) begin
                            r_phase <= phase_t'(w_firstPh[1:0]);
                            r_busy  <= 1'b1;
                            r_state <= ST_ISSUE;
                        end else begin
                            r_finished <= 1'b1;
                            r_state    <= ST_FIN;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!Stall && w_lfsr[0]) begin
                        r_addr   <= w_addr;
                        r_dataIn <= DATA_W'({w_lfsr[6:0], w_lfsr[31:7]});
                        r_wr     <= w_lfsr[1];
                        r_rd     <= !w_lfsr[1];
                        r_nReq   <= r_nReq + 32'd1;
                        r_lat    <= '0;
                        r_state  <= ST_WAIT;
                        if (r_phase == PH_SEQ) r_idx <= w_idxNext;
                        if (r_phase == PH_TWOSET) begin
                            r_idx        <= w_idxTwo;
                            r_tag        <= w_tagTwo;
                            r_pairSecond <= !r_pairSecond;
                        end
                    end
                end
                ST_WAIT: begin
                    // A timeout is retired exactly like a reply that missed, minus the latency check.
                    if (Done || (w_latNext == LAT_TMO)) begin
                        r_rd <= 1'b0;
                        r_wr <= 1'b0;
                        if (Done) begin
                            if (CacheHit) begin
                                r_nHits <= r_nHits + 32'd1;
                                if (!w_hitOk) r_errLat <= 1'b1;
                            end else if (!w_missOk) begin
                                r_errLat <= 1'b1;
                            end
                        end else begin
                            r_errDrop <= 1'b1;
                            r_lat     <= LAT_TMO;
                        end
                        if (r_phCnt == LAST_REQ) begin
                            r_phCnt <= '0;
                            r_state <= ST_NEXTPH;
                        end else begin
                            r_phCnt <= r_phCnt + 32'd1;
                            r_state <= ST_ISSUE;
                        end
                    end else begin
                        r_lat <= w_latNext;
                    end
                end
                ST_NEXTPH: begin
                    r_idx        <= '0;
                    r_tag        <= '0;
                    r_pairSecond <= 1'b0;
                    if (w_nextPh[2]) begin
                        r_phase <= phase_t'(w_nextPh[1:0]);
                        r_state <= ST_ISSUE;
                    end else begin
                        r_busy     <= 1'b0;
                        r_finished <= 1'b1;
                        r_state    <= ST_FIN;
                    end
                end
                default: r_state <= ST_FIN;
            endcase
        end
    end

    assign Addr         = r_addr;
    assign DataIn       = r_dataIn;
    assign Rd           = r_rd;
    assign Wr           = r_wr;
    assign phase        = r_phase;
    assign busy         = r_busy;
    assign finished     = r_finished;
    assign err_latency  = r_errLat;
    assign err_dropped  = r_errDrop;
    assign err_protocol = r_errProt;
    assign n_requests   = r_nReq;
    assign n_hits       = r_nHits;

endmodule
